// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO between a UART receiver and a bus reader, with sticky overflow and idle timeout.
// Latency: a push is visible at rd_data (first-word fall-through) one cycle after rx_done; a pop advances it next cycle.
// Backpressure: none toward the receiver; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_TICKS);

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;

  logic          push_ok;
  logic          pop_ok;
  logic          drop;

  // Accept/drop decisions and next-state for pointers, occupancy, flags and idle timer.
  always_comb begin
    // A pop is only real when data is present; a push into a full FIFO
    // survives only if a pop frees the slot in the same cycle.
    pop_ok     = rd_en && !empty_q;
    push_ok    = rx_done && (!full_q || pop_ok);
    drop       = rx_done && full_q && !pop_ok;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    idle_d     = idle_q;
    timeout_d  = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);

    // A drop in the same cycle as a clear keeps the flag set so the loss is not hidden.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    // Dropped pushes are not activity: the reader still has stale data waiting.
    if (push_ok || pop_ok || empty_q) begin
      idle_d = '0;
    end else if (tick && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + 1'b1;
    end

    timeout_d = (idle_q == IDLE_MAX) && !empty_q && !push_ok && !pop_ok;
  end

  // State registers; storage is left out of reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      idle_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
      timeout_q  <= timeout_d;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  // Head entry is forced to zero while empty so stale bytes never leak to the bus.
  always_comb begin
    rd_data = 8'h00;
    if (!empty_q) begin
      rd_data = mem[rd_ptr_q];
    end
  end

  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule
